multdiv_sequencer: RTL
======================

// Module: multdiv_sequencer
// PURPOSE
//  Sequences the shared iterative multiplier/divider for the 5-stage pipeline. Detects
//  mult/div in DX, pulses the unit's start, stalls the front end and bubbles XM while
//  the unit runs, then holds result/exception/rd for writeback until accepted.
//  Sits between DX decode, the multdiv unit and the W-stage write mux.
// PARAMETERS
//  TIMEOUT_CYCLES  64  BUSY cycles before watchdog abort (only with MULTDIV_SEQ_TIMEOUT_EN)
//  CNT_W           7   width of BUSY cycle counter; must hold TIMEOUT_CYCLES
// PORTS
//  clock         in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-high
//  dx_instr      in   32  instruction in DX
//  dx_valid      in   1   dx_instr is a real instruction (not nop/bubble)
//  flush         in   1   sync pipeline flush (branch/jump taken)
//  md_rdy        in   1   unit result valid (1-cycle pulse)
//  md_exception  in   1   unit error (div by 0 / overflow), valid with md_rdy
//  md_result     in   32  unit result, valid with md_rdy
//  wb_ack        in   1   W stage consumed writeback this cycle
//  md_start_mult out  1   1-cycle start pulse, multiply
//  md_start_div  out  1   1-cycle start pulse, divide
//  stall         out  1   freeze PC/FD/DX
//  nop_xm        out  1   insert bubble into XM (equals stall)
//  wb_valid      out  1   writeback pending
//  wb_rd         out  5   destination register
//  wb_data       out  32  latched result
//  wb_exception  out  1   latched exception flag
//  busy          out  1   state != IDLE
// BEHAVIOUR
//  Decode: is_md = dx_valid & opcode[31:27]==5'b00000 & alu_op[6:2] in {00110 mult, 00111 div}.
//  Reset (async): state=IDLE, counter=0, all outputs 0, wb_data=0, wb_rd=0.
//  States: IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
//   IDLE : is_md & !flush -> ISSUE; latch rd=instr[26:22] and op kind.
//   ISSUE: exactly one cycle; md_start_mult or md_start_div =1 per latched kind -> BUSY.
//   BUSY : counter +1 per cycle; md_rdy -> DONE, latch md_result, md_exception.
//   DONE : wb_valid=1, wb_rd/wb_data/wb_exception stable; wb_ack -> IDLE.
//  stall = (IDLE & is_md) | ISSUE | BUSY | (DONE & !wb_ack); comb, so the mult/div
//   leaves DX in the same cycle as wb_ack and is never re-accepted.
//  Latency: md_rdy at cycle N -> wb_valid at N+1; min accept-to-wb_valid = 3 cycles.
//  md_rdy outside BUSY: ignored. md_rdy in the ISSUE cycle: ignored.
//  flush (any state, priority over all transitions): -> IDLE next edge; wb_valid,
//   start pulses and stall drop; pending result discarded; a following is_md in DX
//   is accepted normally once IDLE.
//  wb_ack outside DONE: ignored. Counter cleared on entry to ISSUE; saturates at 2^CNT_W-1.
//  Reset mid-operation: immediate return to IDLE; unit outputs ignored until new ISSUE.
// CONFIGURATION
//  MULTDIV_SEQ_TIMEOUT_EN defined: in BUSY, counter==TIMEOUT_CYCLES-1 with no md_rdy ->
//   DONE with wb_exception=1, wb_data=32'h0 (watchdog abort; late md_rdy then ignored).
//  Not defined: BUSY waits indefinitely for md_rdy; counter still runs (debug only).
// TESTING
//  mult $3 (rd=3) in DX, md_rdy+result 32'h0000_0030 after 32 BUSY cycles -> one
//   md_start_mult pulse, stall high through DONE, wb_valid/wb_rd=3/wb_data=0x30 next cycle.
//  div with md_exception=1 on md_rdy -> wb_exception=1, wb_ack -> IDLE, stall low same cycle.
//  wb_ack held low 5 cycles in DONE -> outputs stable, stall stays 1, no re-accept.
//  flush during BUSY, then md_rdy 2 cycles later -> IDLE, wb_valid never rises.
//  reset asserted in BUSY -> all outputs 0 asynchronously, next mult accepted cleanly.
//  MULTDIV_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, no md_rdy -> wb_exception=1, wb_data=0
//   after 64 BUSY cycles.

Source files
------------

// File: rtl/multdiv_sequencer_if.sv
// Signal bundle between DX decode, the iterative multdiv unit, the W-stage write mux
// and the multdiv sequencer. The pipeline side uses master; the sequencer uses slave.
interface multdiv_sequencer_if;
    logic [31:0] dx_instr;
    logic        dx_valid;
    logic        flush;
    logic        md_rdy;
    logic        md_exception;
    logic [31:0] md_result;
    logic        wb_ack;
    logic        md_start_mult;
    logic        md_start_div;
    logic        stall;
    logic        nop_xm;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        busy;

    modport master (
        output dx_instr, dx_valid, flush, md_rdy, md_exception, md_result, wb_ack,
        input  md_start_mult, md_start_div, stall, nop_xm, wb_valid, wb_rd, wb_data,
               wb_exception, busy
    );

    modport slave (
        input  dx_instr, dx_valid, flush, md_rdy, md_exception, md_result, wb_ack,
        output md_start_mult, md_start_div, stall, nop_xm, wb_valid, wb_rd, wb_data,
               wb_exception, busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequences the shared iterative mult/div unit: start pulse, front-end stall, result hold
// for writeback. Define MULTDIV_SEQ_TIMEOUT_EN to enable the BUSY watchdog abort.
module multdiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic               clock,
    input  logic               reset,
    multdiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    state_t           state;
    logic [CNT_W-1:0] busy_cnt;
    logic [4:0]       rd_q;
    logic             start_mult_q;
    logic             start_div_q;
    logic             wb_valid_q;
    logic [4:0]       wb_rd_q;
    logic [31:0]      wb_data_q;
    logic             wb_exception_q;
    logic             is_mult;
    logic             is_div;
    logic             is_md;
    logic             timeout_hit;

    assign is_mult = bus.dx_valid && (bus.dx_instr[31:27] == 5'b00000) && (bus.dx_instr[6:2] == ALU_MULT);
    assign is_div  = bus.dx_valid && (bus.dx_instr[31:27] == 5'b00000) && (bus.dx_instr[6:2] == ALU_DIV);
    assign is_md   = is_mult || is_div;

`ifdef MULTDIV_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    assign timeout_hit = (busy_cnt == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy_cnt       <= '0;
            rd_q           <= '0;
            start_mult_q   <= 1'b0;
            start_div_q    <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_exception_q <= 1'b0;
        end else begin
            start_mult_q <= 1'b0;
            start_div_q  <= 1'b0;
            // Flush overrides every transition and discards any pending writeback.
            if (bus.flush) begin
                state      <= IDLE;
                wb_valid_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_md) begin
                            state        <= ISSUE;
                            rd_q         <= bus.dx_instr[26:22];
                            start_mult_q <= is_mult;
                            start_div_q  <= is_div;
                            busy_cnt     <= '0;
                        end
                    end
                    ISSUE: state <= BUSY;
                    BUSY: begin
                        if (busy_cnt != '1) busy_cnt <= busy_cnt + 1'b1;
                        if (bus.md_rdy) begin
                            state          <= DONE;
                            wb_valid_q     <= 1'b1;
                            wb_rd_q        <= rd_q;
                            wb_data_q      <= bus.md_result;
                            wb_exception_q <= bus.md_exception;
                        end else if (timeout_hit) begin
                            state          <= DONE;
                            wb_valid_q     <= 1'b1;
                            wb_rd_q        <= rd_q;
                            wb_data_q      <= 32'h0;
                            wb_exception_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (bus.wb_ack) begin
                            state      <= IDLE;
                            wb_valid_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Combinational so the instruction leaves DX on the same edge that wb_ack retires it.
    assign bus.stall = !reset && ((state == IDLE && is_md) || state == ISSUE || state == BUSY ||
                                  (state == DONE && !bus.wb_ack));
    assign bus.nop_xm        = bus.stall;
    assign bus.md_start_mult = start_mult_q;
    assign bus.md_start_div  = start_div_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_exception  = wb_exception_q;
    assign bus.busy          = (state != IDLE);
endmodule
